// File: rtl/mem_arbiter_if.sv
// Requester port of the two-master RAM arbiter: request handshake plus
// single-cycle response pulse. The arbiter uses the slave modport.
interface mem_arbiter_if #(
  parameter int RAM_SIZE   = 16,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  we_i;
  logic [RAM_SIZE-1:0]   addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [2:0]            wid_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  modport slave (
    input  req_valid_i, we_i, addr_i, wdata_i, wid_i,
    output req_ready_o, rsp_valid_o, rdata_o, err_o
  );

  modport master (
    output req_valid_i, we_i, addr_i, wdata_i, wid_i,
    input  req_ready_o, rsp_valid_o, rdata_o, err_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the LSU (m0) and the debug/loader master (m1)
// for a single registered RAM data port; IDLE -> ISSUE -> RESP per transaction.
module mem_arbiter_lane #(
  parameter int DW = 64
) (
  input  logic          we,
  input  logic [2:0]    addr_lo,
  input  logic [2:0]    wid,
  input  logic          rsp_vld,
  input  logic          rd_ok,
  input  logic [DW-1:0] ram_data,
  output logic          legal,
  output logic [DW-1:0] rdata
);
  always_comb begin
    legal = 1'b1;
    case (wid)
      3'b001, 3'b101: legal = ~addr_lo[0];
      3'b010, 3'b110: legal = (addr_lo[1:0] == 2'b00);
      3'b011:         legal = (addr_lo == 3'b000);
      3'b111:         legal = 1'b0;
      default:        legal = 1'b1;
    endcase
    // stores have no zero-extending form, and 111 is never valid
    if (we && wid[2]) legal = 1'b0;
  end

  assign rdata = (rsp_vld && rd_ok) ? ram_data : '0;
endmodule

module mem_arbiter #(
  parameter int RAM_SIZE   = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          m0,
  mem_arbiter_if.slave          m1,
  output logic                  ram_en_o,
  output logic                  ram_enwr_o,
  output logic [RAM_SIZE-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic [2:0]            ram_wid_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  busy_o
);
  localparam int NUM_M = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state;

  logic [NUM_M-1:0]                 req_vld, req_we, legal, gnt;
  logic [NUM_M-1:0][RAM_SIZE-1:0]   req_addr;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] req_wdata, rdata;
  logic [NUM_M-1:0][2:0]            req_wid;
  logic [NUM_M-1:0]                 gnt_oh, rsp_vld, err;
  logic                             gnt_id, last_grant, rd_ok;

  assign req_vld   = {m1.req_valid_i, m0.req_valid_i};
  assign req_we    = {m1.we_i,        m0.we_i};
  assign req_addr  = {m1.addr_i,      m0.addr_i};
  assign req_wdata = {m1.wdata_i,     m0.wdata_i};
  assign req_wid   = {m1.wid_i,       m0.wid_i};

  for (genvar i = 0; i < NUM_M; i++) begin : g_lane
    mem_arbiter_lane #(.DW(DATA_WIDTH)) u_lane (
      .we       (req_we[i]),
      .addr_lo  (req_addr[i][2:0]),
      .wid      (req_wid[i]),
      .rsp_vld  (rsp_vld[i]),
      .rd_ok    (rd_ok),
      .ram_data (ram_data_i),
      .legal    (legal[i]),
      .rdata    (rdata[i])
    );
  end

  // m1 wins a tie only when m0 took the previous grant
  always_comb begin
    gnt    = '0;
    gnt_id = 1'b0;
    if (state == IDLE && !rst) begin
      if (req_vld[1] && (!req_vld[0] || !last_grant)) begin
        gnt[1] = 1'b1;
        gnt_id = 1'b1;
      end else if (req_vld[0]) begin
        gnt[0] = 1'b1;
      end
    end
  end

  assign m0.req_ready_o = gnt[0];
  assign m1.req_ready_o = gnt[1];
  assign m0.rsp_valid_o = rsp_vld[0];
  assign m1.rsp_valid_o = rsp_vld[1];
  assign m0.err_o       = err[0];
  assign m1.err_o       = err[1];
  assign m0.rdata_o     = rdata[0];
  assign m1.rdata_o     = rdata[1];
  assign busy_o         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_oh     <= '0;
      rsp_vld    <= '0;
      err        <= '0;
      rd_ok      <= 1'b0;
      ram_en_o   <= 1'b0;
      ram_enwr_o <= 1'b1;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      ram_wid_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            last_grant <= gnt_id;
            gnt_oh     <= gnt;
            ram_enwr_o <= ~req_we[gnt_id];
            ram_addr_o <= req_addr[gnt_id];
            ram_data_o <= req_wdata[gnt_id];
            ram_wid_o  <= req_wid[gnt_id];
            if (legal[gnt_id]) begin
              ram_en_o <= 1'b1;
              state    <= ISSUE;
            end else begin
              rsp_vld <= gnt;
              err     <= gnt;
              state   <= RESP;
            end
          end
        end
        ISSUE: begin
          ram_en_o <= 1'b0;
          rsp_vld  <= gnt_oh;
          rd_ok    <= ram_enwr_o;
          state    <= RESP;
        end
        RESP: begin
          rsp_vld <= '0;
          err     <= '0;
          rd_ok   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte RAM (registered read).
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en, ram_enwr, busy;
  logic [15:0] ram_addr;
  logic [63:0] ram_wdata, ram_rdata;
  logic [2:0]  ram_wid;
  logic [7:0]  mem [0:65535];
  int          passed = 0;
  int          total  = 0;

  mem_arbiter_if #(.RAM_SIZE(16), .DATA_WIDTH(64)) m0_if ();
  mem_arbiter_if #(.RAM_SIZE(16), .DATA_WIDTH(64)) m1_if ();

  mem_arbiter #(.RAM_SIZE(16), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .ram_en_o(ram_en), .ram_enwr_o(ram_enwr), .ram_addr_o(ram_addr),
    .ram_data_o(ram_wdata), .ram_wid_o(ram_wid), .ram_data_i(ram_rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // RAM: bytes little-endian, read data sign/zero extended by width code
  always @(posedge clk) begin
    if (ram_en) begin
      int n;
      logic [63:0] v;
      n = 1 << ram_wid[1:0];
      if (!ram_enwr) begin
        for (int i = 0; i < 8; i++)
          if (i < n) mem[16'(ram_addr + 16'(i))] <= ram_wdata[i*8 +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < 8; i++)
          if (i < n) v[i*8 +: 8] = mem[16'(ram_addr + 16'(i))];
        if (!ram_wid[2] && n < 8 && v[n*8-1])
          for (int i = 0; i < 64; i++) if (i >= n*8) v[i] = 1'b1;
        ram_rdata <= v;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic drv(input int m, input logic we, input logic [15:0] a,
                     input logic [63:0] d, input logic [2:0] w);
    if (m == 0) begin
      m0_if.req_valid_i = 1'b1; m0_if.we_i = we; m0_if.addr_i = a;
      m0_if.wdata_i = d; m0_if.wid_i = w;
    end else begin
      m1_if.req_valid_i = 1'b1; m1_if.we_i = we; m1_if.addr_i = a;
      m1_if.wdata_i = d; m1_if.wid_i = w;
    end
  endtask

  task automatic clr(input int m);
    if (m == 0) m0_if.req_valid_i = 1'b0;
    else        m1_if.req_valid_i = 1'b0;
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? m0_if.req_ready_o : m1_if.req_ready_o;
  endfunction
  function automatic logic rsp(input int m);
    return (m == 0) ? m0_if.rsp_valid_o : m1_if.rsp_valid_o;
  endfunction
  function automatic logic er(input int m);
    return (m == 0) ? m0_if.err_o : m1_if.err_o;
  endfunction
  function automatic logic [63:0] rd(input int m);
    return (m == 0) ? m0_if.rdata_o : m1_if.rdata_o;
  endfunction

  // One complete transaction from a lone master with expected outcome
  task automatic txn(input string tag, input int m, input logic we,
                     input logic [15:0] a, input logic [63:0] d, input logic [2:0] w,
                     input logic legal, input logic [63:0] exp_rd);
    drv(m, we, a, d, w);
    #1;
    chk({tag, ".ready"}, 64'(rdy(m)), 64'd1);
    chk({tag, ".other_ready"}, 64'(rdy(1 - m)), 64'd0);
    step();
    clr(m);
    #1;
    if (legal) begin
      chk({tag, ".ram_en"}, 64'(ram_en), 64'd1);
      chk({tag, ".ram_enwr"}, 64'(ram_enwr), 64'(!we));
      chk({tag, ".ram_addr"}, 64'(ram_addr), 64'(a));
      chk({tag, ".ram_wid"}, 64'(ram_wid), 64'(w));
      if (we) chk({tag, ".ram_data"}, ram_wdata, d);
      step();
      chk({tag, ".rsp"}, 64'(rsp(m)), 64'd1);
      chk({tag, ".err"}, 64'(er(m)), 64'd0);
      chk({tag, ".ram_en_resp"}, 64'(ram_en), 64'd0);
    end else begin
      chk({tag, ".ram_en"}, 64'(ram_en), 64'd0);
      chk({tag, ".rsp"}, 64'(rsp(m)), 64'd1);
      chk({tag, ".err"}, 64'(er(m)), 64'd1);
    end
    chk({tag, ".rdata"}, rd(m), exp_rd);
    chk({tag, ".other_rsp"}, 64'(rsp(1 - m)), 64'd0);
    step();
    chk({tag, ".rsp_done"}, 64'(rsp(m)), 64'd0);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'(i + 1);
    ram_rdata = '0;
    m0_if.req_valid_i = 1'b0; m0_if.we_i = 1'b0; m0_if.addr_i = '0;
    m0_if.wdata_i = '0; m0_if.wid_i = '0;
    m1_if.req_valid_i = 1'b0; m1_if.we_i = 1'b0; m1_if.addr_i = '0;
    m1_if.wdata_i = '0; m1_if.wid_i = '0;

    // reset state
    step(); step();
    chk("rst.ram_en", 64'(ram_en), 64'd0);
    chk("rst.ram_enwr", 64'(ram_enwr), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.ram_addr", 64'(ram_addr), 64'd0);
    chk("rst.rsp0", 64'(m0_if.rsp_valid_o), 64'd0);
    rst = 1'b0;

    // tie after reset: grants 0,1,0,1 every three cycles
    drv(0, 1'b0, 16'h0010, 64'd0, 3'b000);
    drv(1, 1'b0, 16'h0011, 64'd0, 3'b000);
    #1;
    chk("tie.c0.ready0", 64'(m0_if.req_ready_o), 64'd1);
    chk("tie.c0.ready1", 64'(m1_if.req_ready_o), 64'd0);
    step();
    chk("tie.c1.ready0", 64'(m0_if.req_ready_o), 64'd0);
    chk("tie.c1.addr", 64'(ram_addr), 64'h10);
    step();
    chk("tie.c2.rsp0", 64'(m0_if.rsp_valid_o), 64'd1);
    chk("tie.c2.rdata0", m0_if.rdata_o, 64'h01);
    chk("tie.c2.rsp1", 64'(m1_if.rsp_valid_o), 64'd0);
    step();
    chk("tie.c3.ready1", 64'(m1_if.req_ready_o), 64'd1);
    chk("tie.c3.ready0", 64'(m0_if.req_ready_o), 64'd0);
    step();
    chk("tie.c4.addr", 64'(ram_addr), 64'h11);
    step();
    chk("tie.c5.rsp1", 64'(m1_if.rsp_valid_o), 64'd1);
    chk("tie.c5.rdata1", m1_if.rdata_o, 64'h02);
    chk("tie.c5.rdata0", m0_if.rdata_o, 64'h0);
    step();
    chk("tie.c6.ready0", 64'(m0_if.req_ready_o), 64'd1);
    step(); step(); step();
    chk("tie.c9.ready1", 64'(m1_if.req_ready_o), 64'd1);
    step();
    clr(0); clr(1);
    step();
    chk("tie.c11.rsp1", 64'(m1_if.rsp_valid_o), 64'd1);
    step();
    chk("tie.c12.busy", 64'(busy), 64'd0);

    // single D read
    txn("rdD", 0, 1'b0, 16'h0010, 64'd0, 3'b011, 1'b1, 64'h0807060504030201);

    // misaligned W write from m1: no RAM access, memory untouched
    txn("misW", 1, 1'b1, 16'h0006, 64'hAABBCCDD, 3'b010, 1'b0, 64'd0);
    chk("misW.mem6", 64'(mem[6]), 64'h00);
    chk("misW.mem7", 64'(mem[7]), 64'h00);

    // illegal widths and a legal HU read
    txn("wrBU", 0, 1'b1, 16'h0000, 64'h55, 3'b100, 1'b0, 64'd0);
    chk("wrBU.mem0", 64'(mem[0]), 64'h00);
    txn("rd111", 0, 1'b0, 16'h0000, 64'd0, 3'b111, 1'b0, 64'd0);
    txn("rdHU2", 0, 1'b0, 16'h0002, 64'd0, 3'b101, 1'b1, 64'd0);
    txn("rdD4", 1, 1'b0, 16'h0014, 64'd0, 3'b011, 1'b0, 64'd0);

    // write H then read back zero- and sign-extended
    txn("wrH", 0, 1'b1, 16'h0020, 64'h123456789ABCBEEF, 3'b001, 1'b1, 64'd0);
    chk("wrH.mem22", 64'(mem[16'h22]), 64'h00);
    txn("rdHU", 0, 1'b0, 16'h0020, 64'd0, 3'b101, 1'b1, 64'h000000000000BEEF);
    txn("rdH", 0, 1'b0, 16'h0020, 64'd0, 3'b001, 1'b1, 64'hFFFFFFFFFFFFBEEF);

    // reset while in ISSUE
    drv(0, 1'b1, 16'h0030, 64'h1122334455667788, 3'b011);
    #1;
    chk("rstI.ready", 64'(m0_if.req_ready_o), 64'd1);
    step();
    clr(0);
    chk("rstI.en_before", 64'(ram_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstI.en", 64'(ram_en), 64'd0);
    chk("rstI.busy", 64'(busy), 64'd0);
    chk("rstI.enwr", 64'(ram_enwr), 64'd1);
    chk("rstI.rsp0", 64'(m0_if.rsp_valid_o), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("rstI.rsp0_after", 64'(m0_if.rsp_valid_o), 64'd0);
    txn("postRst", 1, 1'b0, 16'h0010, 64'd0, 3'b000, 1'b1, 64'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 16, meaning the RAM byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning the data-port width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide two requester ports, N in {0,1}, each with the signals in REQ-006 to REQ-014; port 0 is the LSU and port 1 is the debug/loader master.
REQ-006 mN_req_valid_i, input, 1: request present.
REQ-007 mN_req_ready_o, output, 1: request accepted this cycle.
REQ-008 mN_we_i, input, 1: 1 = write, 0 = read.
REQ-009 mN_addr_i, input, RAM_SIZE: byte address.
REQ-010 mN_wdata_i, input, DATA_WIDTH: write data, little-endian, LSB-aligned.
REQ-011 mN_wid_i, input, 3: access width using codes B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110.
REQ-012 mN_rsp_valid_o, output, 1: one-cycle response pulse.
REQ-013 mN_rdata_o, output, DATA_WIDTH: read data, already extended by the RAM.
REQ-014 mN_err_o, output, 1: the request was rejected (misaligned or illegal width).
REQ-015 ram_en_o, output, 1: RAM data-port enable.
REQ-016 ram_enwr_o, output, 1: 0 = write, 1 = read (the RAM encoding).
REQ-017 ram_addr_o, output, RAM_SIZE.
REQ-018 ram_data_o, output, DATA_WIDTH.
REQ-019 ram_wid_o, output, 3.
REQ-020 ram_data_i, input, DATA_WIDTH: RAM read data, registered inside the RAM (valid the cycle after the enable).
REQ-021 busy_o, output, 1: the FSM is not in IDLE.

Function
REQ-022 SHALL implement the FSM states IDLE, ISSUE, RESP.
REQ-023 SHALL, in IDLE with any mN_req_valid_i, grant exactly one master and assert only that master's mN_req_ready_o (combinational).
  - Latch we, addr, wdata, wid and the grant ID in that same cycle.
  - Go to ISSUE if the request is legal, otherwise to RESP with the error flag set.
REQ-024 SHALL drive both mN_req_ready_o low outside IDLE.
REQ-025 SHALL arbitrate round-robin: with both masters valid, grant the master not granted last; a lone valid master is always granted; last_grant updates on every grant.
REQ-026 SHALL, in ISSUE, drive ram_en_o=1 with the latched fields for exactly one cycle, then go to RESP; ram_en_o SHALL be 0 in every other state.
REQ-027 SHALL, in RESP, pulse the granted master's rsp_valid for one cycle and then return to IDLE; a new grant is possible in the next cycle, so throughput is at most one transaction per 3 cycles.
REQ-028 SHALL, in RESP for a legal read, drive rdata = ram_data_i; for a write or an error, rdata = 0.
REQ-029 SHALL set err = 1 in RESP only for a rejected request; the non-granted master's rsp_valid, rdata and err SHALL stay 0.
REQ-030 SHALL reject a request when any of these holds (applies to both reads and writes):
  - H/HU with addr[0] != 0;
  - W/WU with addr[1:0] != 0;
  - D with addr[2:0] != 0;
  - wid = 111;
  - a write with wid BU, HU or WU.
REQ-031 SHALL never assert ram_en_o for a rejected request.
REQ-032 SHALL provide no response backpressure; masters SHALL accept the rsp_valid pulse.
REQ-033 SHALL hold ram_addr_o, ram_data_o, ram_wid_o and ram_enwr_o at the latched values while not in ISSUE (no glitching required, values ignored).

Reset
REQ-034 SHALL, while rst=1 (asynchronously):
  - set state IDLE and last_grant=1, so master 0 wins the first tie;
  - drive all outputs to 0, except ram_enwr_o=1 (read).
REQ-035 SHALL, when rst asserts mid-transaction, discard the transaction with no response pulse; a write in ISSUE may be lost.

Verification
REQ-036 Single read: m0 reads D at 0x0010 with RAM bytes 0x01..0x08 -> ready in cycle 0, ram_en_o in cycle 1, m0_rsp_valid_o in cycle 2 with rdata 0x0807060504030201 and err 0.
REQ-037 Tie: m0 and m1 both request after reset -> m0 granted first, m1 granted in cycle 3; with both held valid the grants alternate 0,1,0,1.
REQ-038 Misaligned: m1 writes W to 0x0006 -> rsp_valid in cycle 1 with err=1, ram_en_o never asserted, RAM contents unchanged.
REQ-039 Illegal width: write BU to 0x0000 -> err=1; read wid 111 -> err=1; read HU at 0x0002 -> legal, err=0.
REQ-040 Write then read back: m0 writes H 0xBEEF to 0x0020, then reads HU from 0x0020 -> rdata 0x000000000000BEEF; reading H returns 0xFFFFFFFFFFFFBEEF.
REQ-041 Reset during ISSUE -> ram_en_o drops immediately, no rsp_valid, busy_o=0, and the next request is granted normally.
